// File: rtl/dsp_stim_drv.sv
// dsp_stim_drv: serial-loaded 128-bit stimulus bus and windowed dout counter.
// Optional macro DSP_STIM_LFSR_EN: din runs as a 128-bit LFSR during OBSERVE.
module dsp_stim_drv #(
    parameter int unsigned SETTLE = 4,
    parameter int unsigned WINDOW = 256,
    parameter int unsigned CW     = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sdi,
    input  logic          sen,
    input  logic          sload,
    output logic [127:0]  din,
    input  logic          dout,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] cnt,
    output logic          ovr
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_OBSERVE,
        S_DONE
    } state_t;

    localparam logic [7:0]  SET_LAST = 8'(SETTLE - 1);
    localparam logic [15:0] WIN_LAST = 16'(WINDOW - 1);

    state_t        state_q;
    logic [127:0]  shreg_q;
    logic [127:0]  shreg_d;
    logic [127:0]  din_q;
    logic [7:0]    set_q;
    logic [15:0]   smp_q;
    logic [CW-1:0] acc_q;
    logic [CW-1:0] acc_d;
    logic [CW-1:0] cnt_q;
    logic          busy_q;
    logic          done_q;
    logic          ovr_q;

    // Next shift-register value: MSB-first serial entry at bit 0.
    always_comb begin
        shreg_d = shreg_q;
        if (sen) begin
            shreg_d = {shreg_q[126:0], sdi};
        end
    end

    // Saturating accumulate of the current dout sample.
    always_comb begin
        acc_d = acc_q;
        if (dout && (acc_q != {CW{1'b1}})) begin
            acc_d = acc_q + CW'(1);
        end
    end

`ifdef DSP_STIM_LFSR_EN
    logic fb;

    // Fibonacci feedback taps of the free-running stimulus pattern.
    always_comb begin
        fb = din_q[127] ^ din_q[125] ^ din_q[100] ^ din_q[98];
    end
`endif

    // Shift register runs independently of the run state.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    // Run controller: load, settle, observe window, report.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            din_q   <= '0;
            set_q   <= '0;
            smp_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (sload) begin
                        din_q   <= shreg_q;
                        set_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (sload) begin
                        ovr_q <= 1'b1;
                    end
                    if (set_q == SET_LAST) begin
                        smp_q   <= '0;
                        acc_q   <= '0;
                        state_q <= S_OBSERVE;
                    end else begin
                        set_q <= set_q + 8'd1;
                    end
                end
                S_OBSERVE: begin
                    if (sload) begin
                        ovr_q <= 1'b1;
                    end
`ifdef DSP_STIM_LFSR_EN
                    din_q <= {din_q[126:0], fb};
`endif
                    acc_q <= acc_d;
                    if (smp_q == WIN_LAST) begin
                        cnt_q   <= acc_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end else begin
                        smp_q <= smp_q + 16'd1;
                    end
                end
                S_DONE: begin
                    if (sload) begin
                        ovr_q <= 1'b1;
                    end
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign din  = din_q;
    assign busy = busy_q;
    assign done = done_q;
    assign cnt  = cnt_q;
    assign ovr  = ovr_q;

endmodule

// File: tb/tb_dsp_stim_drv.sv
// tb_dsp_stim_drv: scoreboard bench for dsp_stim_drv at default parameters.
// Honours DSP_STIM_LFSR_EN when the design is built with it.
module tb_dsp_stim_drv;

    logic         clk = 1'b0;
    logic         rst;
    logic         sdi;
    logic         sen;
    logic         sload;
    logic [127:0] din;
    logic         dout;
    logic         busy;
    logic         done;
    logic [8:0]   cnt;
    logic         ovr;

    int         n_chk  = 0;
    int         n_fail = 0;
    logic [8:0] sb[$];
    logic       exp_ovr;

    always #5 clk = ~clk;

    dsp_stim_drv dut (
        .clk   (clk),
        .rst   (rst),
        .sdi   (sdi),
        .sen   (sen),
        .sload (sload),
        .din   (din),
        .dout  (dout),
        .busy  (busy),
        .done  (done),
        .cnt   (cnt),
        .ovr   (ovr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] lfsr_step(input logic [127:0] v);
        return {v[126:0], v[127] ^ v[125] ^ v[100] ^ v[98]};
    endfunction

    task automatic apply_reset();
        rst = 1'b1; sen = 1'b0; sload = 1'b0; dout = 1'b0; sdi = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        exp_ovr = 1'b0;
        sb.delete();
    endtask

    task automatic shift_in(input logic [127:0] v);
        for (int i = 127; i >= 0; i--) begin
            sen = 1'b1;
            sdi = v[i];
            tick();
        end
        sen = 1'b0;
        sdi = 1'b0;
    endtask

    // Cycle k = the k-th cycle after the load edge; dout high for k in [lo,hi].
    task automatic do_run(input string nm, input logic [127:0] seed,
                          input int lo, input int hi, input int ld_at,
                          input int sen_at, input int rst_at,
                          output logic [127:0] din7);
        logic [127:0] exp_din;
        logic [8:0]   exp_cnt;
        logic [8:0]   got;
        bit           seen;
        exp_cnt = '0;
        for (int k = 5; k <= 260; k++)
            if (k >= lo && k <= hi) exp_cnt++;
        shift_in(seed);
        sen   = 1'b1;
        sdi   = ~seed[0];
        sload = 1'b1;
        tick();
        sen   = 1'b0;
        sload = 1'b0;
        if (rst_at == 0) sb.push_back(exp_cnt);
        exp_din = seed;
        din7    = seed;
        n_chk++;
        if (din !== exp_din) begin
            n_fail++;
            $display("FAIL %s load_din got %h want %h", nm, din, exp_din);
        end
        n_chk++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s load_busy got %b want 1", nm, busy);
        end
        seen = 0;
        for (int k = 1; k <= 262; k++) begin
            dout  = (k >= lo && k <= hi);
            sload = (k == ld_at);
            sen   = (sen_at != 0 && k >= sen_at && k < sen_at + 5);
            sdi   = 1'($urandom_range(0, 1));
            rst   = (k == rst_at);
            tick();
            dout = 1'b0; sload = 1'b0; sen = 1'b0; rst = 1'b0;
            if (k == rst_at) begin
                exp_ovr = 1'b0;
                n_chk++;
                if ({din, cnt, busy, done, ovr} !== '0) begin
                    n_fail++;
                    $display("FAIL %s rst_outs din=%h cnt=%0d busy=%b done=%b ovr=%b want all 0",
                             nm, din, cnt, busy, done, ovr);
                end
                return;
            end
            if (k == ld_at) exp_ovr = 1'b1;
`ifdef DSP_STIM_LFSR_EN
            if (k >= 5 && k <= 260) exp_din = lfsr_step(exp_din);
`endif
            if (k == 7) din7 = din;
            n_chk++;
            if (din !== exp_din) begin
                n_fail++;
                $display("FAIL %s din k=%0d got %h want %h", nm, k, din, exp_din);
            end
            n_chk++;
            if (busy !== (k <= 259)) begin
                n_fail++;
                $display("FAIL %s busy k=%0d got %b want %b", nm, k, busy, k <= 259);
            end
            n_chk++;
            if (done !== (k == 260)) begin
                n_fail++;
                $display("FAIL %s done k=%0d got %b want %b", nm, k, done, k == 260);
            end
            n_chk++;
            if (ovr !== exp_ovr) begin
                n_fail++;
                $display("FAIL %s ovr k=%0d got %b want %b", nm, k, ovr, exp_ovr);
            end
            if (done === 1'b1) begin
                seen = 1;
                n_chk++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s sb_empty got done want no done", nm);
                end else begin
                    got = sb.pop_front();
                    if (cnt !== got) begin
                        n_fail++;
                        $display("FAIL %s cnt got %0d want %0d", nm, cnt, got);
                    end
                end
            end
        end
        n_chk++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s done_timeout got none want pulse", nm);
        end
        n_chk++;
        if (cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL %s cnt_hold got %0d want %0d", nm, cnt, exp_cnt);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        dout = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_chk++;
            if ({din, cnt, busy, done, ovr} !== '0) begin
                n_fail++;
                $display("FAIL reset_idle i=%0d din=%h cnt=%0d busy=%b done=%b ovr=%b want all 0",
                         i, din, cnt, busy, done, ovr);
            end
        end
        dout = 1'b0;
    endtask

    task automatic test_load_latency();
        logic [127:0] d7;
        do_run("load", 128'h8000_0000_0000_0000_0000_0000_0000_0001,
               1, 262, 0, 0, 0, d7);
    endtask

    task automatic test_count();
        logic [127:0] d7;
        do_run("cnt37", {4{32'hA5A5_5A5A}}, 10, 46, 0, 0, 0, d7);
        do_run("settle_only", 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
               1, 4, 0, 0, 0, d7);
        do_run("first_sample", 128'h5, 5, 5, 0, 0, 0, d7);
        do_run("last_sample", 128'h6, 260, 261, 0, 0, 0, d7);
    endtask

    task automatic test_overrun();
        logic [127:0] d7;
        apply_reset();
        do_run("ovr50", {2{64'hDEAD_BEEF_CAFE_F00D}}, 30, 200, 50, 120, 0, d7);
        for (int i = 0; i < 5; i++) begin
            tick();
            n_chk++;
            if (ovr !== 1'b1) begin
                n_fail++;
                $display("FAIL ovr_sticky i=%0d got %b want 1", i, ovr);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        logic [127:0] d7;
        apply_reset();
        do_run("rst_mid", {4{32'h1357_9BDF}}, 1, 262, 0, 0, 104, d7);
        for (int i = 0; i < 5; i++) begin
            tick();
            n_chk++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_mid_quiet i=%0d done=%b busy=%b want 0 0", i, done, busy);
            end
        end
        do_run("after_rst", {4{32'h2468_ACE0}}, 100, 149, 0, 0, 0, d7);
    endtask

    task automatic test_done_overrun();
        logic [127:0] d7;
        apply_reset();
        do_run("ovr_done", 128'hF0F0, 1, 262, 261, 0, 0, d7);
    endtask

    task automatic test_lfsr();
        logic [127:0] d7;
        logic [127:0] want;
        apply_reset();
        do_run("seed1", 128'h1, 0, 0, 0, 0, 0, d7);
`ifdef DSP_STIM_LFSR_EN
        want = 128'h8;
`else
        want = 128'h1;
`endif
        n_chk++;
        if (d7 !== want) begin
            n_fail++;
            $display("FAIL lfsr_seed1 got %h want %h", d7, want);
        end
        do_run("seed0", 128'h0, 20, 30, 0, 0, 0, d7);
        n_chk++;
        if (din !== 128'h0) begin
            n_fail++;
            $display("FAIL lfsr_seed0 got %h want 0", din);
        end
    endtask

    initial begin
        rst = 1'b1; sdi = 1'b0; sen = 1'b0; sload = 1'b0; dout = 1'b0;
        exp_ovr = 1'b0;
        test_reset();
        test_load_latency();
        test_count();
        test_overrun();
        test_reset_mid_run();
        test_done_overrun();
        test_lfsr();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
